// File: rtl/raster_scan_counter_if.sv
// Bundles the control inputs, region descriptor and beat outputs of raster_scan_counter.
// master = the scan generator, slave = the block that drives it and consumes its beats.
interface raster_scan_counter_if #(
    parameter int unsigned XBits    = 9,
    parameter int unsigned YBits    = 8,
    parameter int unsigned AddrBits = 17
) ();

    logic                start;
    logic                abort;
    logic [XBits-1:0]    x_limit;
    logic [YBits-1:0]    y_limit;
    logic [AddrBits-1:0] base_addr;
    logic                ready;

    logic                valid;
    logic [XBits-1:0]    x;
    logic [YBits-1:0]    y;
    logic [AddrBits-1:0] addr;
    logic                last;
    logic                busy;
    logic                done;

    modport master (
        input  start, abort, x_limit, y_limit, base_addr, ready,
        output valid, x, y, addr, last, busy, done
    );

    modport slave (
        output start, abort, x_limit, y_limit, base_addr, ready,
        input  valid, x, y, addr, last, busy, done
    );

endinterface

// File: rtl/raster_scan_counter.sv
// Raster-order 2-D scan generator: walks an x_limit by y_limit region, emitting x, y and a
// linear frame-buffer address per beat over a valid/ready handshake, with done and abort.
module raster_scan_counter #(
    parameter int unsigned XBits    = 9,
    parameter int unsigned YBits    = 8,
    parameter int unsigned AddrBits = 17
) (
    input logic                   clk,
    input logic                   reset,
    raster_scan_counter_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [XBits-1:0]    x_q, x_d;
    logic [YBits-1:0]    y_q, y_d;
    logic [AddrBits-1:0] addr_q, addr_d;
    logic [XBits-1:0]    x_lim_q, x_lim_d;
    logic [YBits-1:0]    y_lim_q, y_lim_d;
    logic [AddrBits-1:0] base_q, base_d;

    logic at_x_end;
    logic at_y_end;
    logic last_w;
    logic handshake;

    // Limits are never zero while in StScan, so limit-1 cannot underflow where it matters.
    assign at_x_end  = (x_q == x_lim_q - XBits'(1));
    assign at_y_end  = (y_q == y_lim_q - YBits'(1));
    assign last_w    = valid_q && at_x_end && at_y_end;
    assign handshake = valid_q && bus.ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        x_lim_d = x_lim_q;
        y_lim_d = y_lim_q;
        base_d  = base_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    x_lim_d = bus.x_limit;
                    y_lim_d = bus.y_limit;
                    base_d  = bus.base_addr;
                    if ((bus.x_limit != '0) && (bus.y_limit != '0)) begin
                        state_d = StScan;
                        valid_d = 1'b1;
                        x_d     = '0;
                        y_d     = '0;
                        addr_d  = bus.base_addr;
                    end else begin
                        // Empty region: skip straight to the completion pulse.
                        state_d = StDone;
                    end
                end
            end

            StScan: begin
                if (bus.abort) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end else if (handshake) begin
                    addr_d = addr_q + AddrBits'(1);
                    if (last_w) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                    end else if (at_x_end) begin
                        x_d = '0;
                        y_d = y_q + YBits'(1);
                    end else begin
                        x_d = x_q + XBits'(1);
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end

            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            x_lim_q <= '0;
            y_lim_q <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            x_lim_q <= x_lim_d;
            y_lim_q <= y_lim_d;
            base_q  <= base_d;
        end
    end

    assign bus.valid = valid_q;
    assign bus.x     = x_q;
    assign bus.y     = y_q;
    assign bus.addr  = addr_q;
    assign bus.last  = last_w;
    assign bus.busy  = (state_q != StIdle);
    assign bus.done  = (state_q == StDone);

endmodule
